inv_bist: RTL and testbench

//   Synthesizable built-in self-test for an N-bit inverter (inverse role of the

---
 rtl/inv_bist.sv | 90 +++++++++
 tb/tb_inv_bist.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/inv_bist.sv
// Built-in self-test for an N-bit inverter: sweeps every input vector
// and checks each response against the bitwise complement.
module inv_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_x,
    input  logic [WIDTH-1:0] i_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [WIDTH:0]   o_err_cnt,
    output logic             o_first_err_vld,
    output logic [WIDTH-1:0] o_first_err_x
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          last_x;

    assign mismatch = (i_y != ~o_x);
    assign last_x   = &o_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            o_x             <= '0;
            o_err_cnt       <= '0;
            o_first_err_vld <= 1'b0;
            o_first_err_x   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state           <= S_WAIT;
                        cnt             <= '0;
                        o_x             <= '0;
                        o_err_cnt       <= '0;
                        o_first_err_vld <= 1'b0;
                        o_first_err_x   <= '0;
                    end
                end
                S_WAIT: begin
                    if (cnt == LAST) begin
                        state <= S_CHECK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        o_err_cnt <= o_err_cnt + 1'b1;
                        if (!o_first_err_vld) begin
                            o_first_err_vld <= 1'b1;
                            o_first_err_x   <= o_x;
                        end
                    end
                    // Stop on all-ones so o_x never wraps back to zero.
                    if (last_x) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                        o_x   <= o_x + 1'b1;
                        cnt   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy = (state == S_WAIT) || (state == S_CHECK);
    assign o_done = (state == S_DONE);
    assign o_pass = o_done && (o_err_cnt == '0);

endmodule

// File: tb/tb_inv_bist.sv
// Bench for inv_bist: two instances (SETTLE=1 and SETTLE=3) with a
// configurable faulty inverter model and a sweep-progress reference model.
module tb_inv_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start3 = 1'b0;
    int         mode1 = 0;
    int         mode3 = 0;

    logic [3:0] x1, y1, fx1, x3, y3, fx3;
    logic       busy1, done1, pass1, vld1;
    logic       busy3, done3, pass3, vld3;
    logic [4:0] err1, err3;

    int checks = 0;
    int failures = 0;
    bit go = 1'b0;

    // Sweep progress: -1 idle, else edges since the accepted start edge.
    int n1 = -1;
    int n3 = -1;
    int mm1 = 0;
    int mm3 = 0;
    int edges;

    always #5 clk = ~clk;

    function automatic logic [3:0] resp(int md, logic [3:0] x);
        case (md)
            1: return ~x & 4'b1110;
            2: return (x == 4'd9) ? 4'd0 : ~x;
            default: return ~x;
        endcase
    endfunction

    assign y1 = resp(mode1, x1);
    assign y3 = resp(mode3, x3);

    inv_bist #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .i_start(start1), .o_x(x1), .i_y(y1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_err_cnt(err1), .o_first_err_vld(vld1), .o_first_err_x(fx1)
    );

    inv_bist #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .i_start(start3), .o_x(x3), .i_y(y3),
        .o_busy(busy3), .o_done(done3), .o_pass(pass3),
        .o_err_cnt(err3), .o_first_err_vld(vld3), .o_first_err_x(fx3)
    );

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic upd(inout int n, inout int mm, input logic st,
                       input int md, input int total);
        if (rst) n = -1;
        else if (st && (n < 0 || n >= total)) begin
            n = 0;
            mm = md;
        end else if (n >= 0 && n < total) n++;
    endtask

    always @(posedge clk) begin
        upd(n1, mm1, start1, mode1, 32);
        upd(n3, mm3, start3, mode3, 64);
    end

    task automatic cmp(string nm, int n, int s, int md,
                       logic busy, logic done, logic pass, logic [3:0] x,
                       logic [4:0] err, logic vld, logic [3:0] fx);
        int total, chk, e_err, e_first, e_x;
        bit e_vld, e_done, e_busy;
        total = 16 * (s + 1);
        e_err = 0; e_first = 0; e_vld = 0; e_done = 0; e_busy = 0; e_x = 0;
        if (n >= 0) begin
            e_done = (n >= total);
            e_busy = !e_done;
            chk = n / (s + 1);
            if (chk > 16) chk = 16;
            e_x = e_done ? 15 : n / (s + 1);
            for (int v = 0; v < chk; v++) begin
                if (resp(md, 4'(v)) != ~4'(v)) begin
                    if (!e_vld) e_first = v;
                    e_vld = 1;
                    e_err++;
                end
            end
        end
        check({nm, ".busy"}, int'(busy), int'(e_busy));
        check({nm, ".done"}, int'(done), int'(e_done));
        check({nm, ".pass"}, int'(pass), int'(e_done && e_err == 0));
        check({nm, ".x"}, int'(x), e_x);
        check({nm, ".err"}, int'(err), e_err);
        check({nm, ".vld"}, int'(vld), int'(e_vld));
        check({nm, ".fx"}, int'(fx), e_first);
    endtask

    always @(negedge clk) begin
        if (go) begin
            cmp("m1", n1, 1, mm1, busy1, done1, pass1, x1, err1, vld1, fx1);
            cmp("m3", n3, 3, mm3, busy3, done3, pass3, x3, err3, vld3, fx3);
        end
    end

    task automatic wait_done(input int sel, input int pulse_at, output int e);
        e = 0;
        while (!(sel == 1 ? done1 : done3) && e < 300) begin
            @(negedge clk);
            e++;
            if (sel == 1) start1 = (e == pulse_at);
            else start3 = (e == pulse_at);
        end
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic sweep(input int sel, input int md, input int pulse_at,
                         output int e);
        if (sel == 1) begin mode1 = md; start1 = 1'b1; end
        else begin mode3 = md; start3 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        wait_done(sel, pulse_at, e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        go = 1'b1;
        check("rst.busy", int'(busy1), 0);
        check("rst.x", int'(x1), 0);
        check("rst.err", int'(err1), 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(1, 0, -1, edges);
        check("t1.edges", edges, 32);
        check("t1.err", int'(err1), 0);
        check("t1.pass", int'(pass1), 1);
        check("t1.vld", int'(vld1), 0);
        check("t1.x", int'(x1), 15);

        sweep(1, 1, -1, edges);
        check("t2.edges", edges, 32);
        check("t2.err", int'(err1), 8);
        check("t2.fx", int'(fx1), 0);
        check("t2.pass", int'(pass1), 0);

        sweep(1, 2, -1, edges);
        check("t3.err", int'(err1), 1);
        check("t3.fx", int'(fx1), 9);
        check("t3.vld", int'(vld1), 1);

        sweep(1, 1, 7, edges);
        check("t4.edges", edges, 32);
        check("t4.err", int'(err1), 8);

        mode1 = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (11) @(negedge clk);
        check("t5.pre_x", int'(x1), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5.x", int'(x1), 0);
        check("t5.busy", int'(busy1), 0);
        check("t5.err", int'(err1), 0);
        sweep(1, 2, -1, edges);
        check("t5.edges", edges, 32);
        check("t5.fx", int'(fx1), 9);

        sweep(3, 1, -1, edges);
        check("t6.edges", edges, 64);
        check("t6.err", int'(err3), 8);
        mode3 = 0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("t6.clr_err", int'(err3), 0);
        check("t6.clr_done", int'(done3), 0);
        wait_done(3, -1, edges);
        check("t6.edges2", edges, 64);
        check("t6.pass", int'(pass3), 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
